// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: feeds one external full-adder cell LSB first and
// collects the WIDTH-bit sum plus final carry behind valid/ready handshakes.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_c_out;
    logic             w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                fa_a   = r_a_sh[0];
                fa_b   = r_b_sh[0];
                fa_cin = r_carry;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Result lives in its own register so it survives the next operand load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_c_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= b_in;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum_sh <= {fa_s, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum_out <= {fa_s, r_sum_sh[WIDTH-1:1]};
                        r_c_out   <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_out = r_sum_out;
    assign c_out   = r_c_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural full-adder cell on the fa_* pins and an
// arithmetic reference for every serial step and the final result.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         c_out;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_c = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_s(fa_s), .fa_cout(fa_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .c_out(c_out)
    );

    // External full-adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands from IDLE, follow every serial step, check the result in DONE.
    task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0]  full;
        int unsigned lo;
        full = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            lo = (int'(a) & ((1 << i) - 1)) + (int'(b) & ((1 << i) - 1)) + int'(c);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("run_fa_a", 32'(fa_a), 32'(a[i]));
            chk("run_fa_b", 32'(fa_b), 32'(b[i]));
            chk("run_fa_cin", 32'((lo >> i) & 1), 32'(fa_cin)) ;
            // Inputs that must be ignored while running
            in_valid  = 1'($urandom);
            a_in      = W'($urandom);
            out_ready = 1'($urandom);
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_sum = full[W-1:0];
        exp_c   = full[W];
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_sum", 32'(sum_out), 32'(exp_sum));
        chk("done_cout", 32'(c_out), 32'(exp_c));
        chk("done_fa_a", 32'(fa_a), 32'd0);
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_sum_hold", 32'(sum_out), 32'(exp_sum));
        chk("rel_cout_hold", 32'(c_out), 32'(exp_c));
    endtask

    // Accept result while the next operands already wait on in_valid.
    task automatic b2b_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        tick;
        out_ready = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd0);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        start_add(a, b, c);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;

        // Directed sums, including wrap and full-carry cases
        start_add(8'h5A, 8'h3C, 1'b0);
        chk("t1_sum", 32'(sum_out), 32'h96);
        release_result;
        start_add(8'hFF, 8'h01, 1'b0);
        chk("t2a_sum", 32'({c_out, sum_out}), 32'h100);
        release_result;
        start_add(8'hFF, 8'hFF, 1'b1);
        chk("t2b_sum", 32'({c_out, sum_out}), 32'h1FF);
        release_result;
        start_add(8'h01, 8'h01, 1'b1);
        chk("t3_sum", 32'({c_out, sum_out}), 32'h003);
        release_result;

        // Backpressure in DONE with ignored operand pulses
        start_add(W'($urandom), W'($urandom), 1'($urandom));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom);
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            tick;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum", 32'(sum_out), 32'(exp_sum));
            chk("bp_cout", 32'(c_out), 32'(exp_c));
        end
        in_valid = 1'b0;
        release_result;

        // Reset abort in the middle of a run
        in_valid = 1'b1;
        a_in = 8'hA7;
        b_in = 8'h6E;
        c_in = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_cout", 32'(c_out), 32'd0);
        tick;
        rst_n = 1'b1;
        start_add(8'h10, 8'h20, 1'b0);
        chk("t5_sum", 32'({c_out, sum_out}), 32'h030);

        // Back-to-back random traffic
        for (int n = 0; n < 200; n++)
            b2b_add(W'($urandom), W'($urandom), 1'($urandom));
        release_result;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
